// File: rtl/div_const_pkg.sv
// Shared constants and types for the sequenced constant-divider controller.
// Optional feature macro: QUOTIENT_EN (adds the quotient register and port).
package div_const_pkg;

  localparam int W      = 32;  // operand width
  localparam int D      = 11;  // constant divisor, 2..63
  localparam int CHUNK  = 6;   // digit width consumed per step

  // Digits per operand; the operand is zero-padded at the MSB end to PW bits.
  localparam int NCHUNK = (W + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;

  // The remainder is always < D, so RW bits suffice.
  // The step value v = racc*2^CHUNK + chunk is < D*2^CHUNK and fits in VW bits.
  localparam int RW     = $clog2(D);
  localparam int VW     = RW + CHUNK;
  localparam int TBL    = D * (2 ** CHUNK);

  // Step counter width. It is kept at least 1 bit wide.
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [RW-1:0] res_t;

endpackage

// File: rtl/div_const_step.sv
// One chunk-residue step: v = racc*2^CHUNK + chunk, returns v mod D and v div D.
// Both results are read from constant tables that are built from D at elaboration.
// With QUOTIENT_EN undefined, the digit table and the digit output are absent.
module div_const_step
  import div_const_pkg::*;
(
  input  res_t             racc_i,
  input  logic [CHUNK-1:0] chunk_i,
  output res_t             r_next_o
`ifdef QUOTIENT_EN
  ,
  output logic [CHUNK-1:0] q_dig_o
`endif
);

  // Multiplying by 2^CHUNK is a concatenation.
  logic [VW-1:0] v;
  assign v = {racc_i, chunk_i};

  res_t rem_tbl [TBL];
`ifdef QUOTIENT_EN
  logic [CHUNK-1:0] dig_tbl [TBL];
`endif

  for (genvar i = 0; i < TBL; i++) begin : g_tbl
    assign rem_tbl[i] = res_t'(i % D);
`ifdef QUOTIENT_EN
    // i < D*2^CHUNK, so i/D < 2^CHUNK and the digit is exact in CHUNK bits.
    assign dig_tbl[i] = CHUNK'(i / D);
`endif
  end

  // Table lookup. The guard covers unreachable indices (racc >= D).
  always_comb begin
    r_next_o = '0;
`ifdef QUOTIENT_EN
    q_dig_o  = '0;
`endif
    if (int'(v) < TBL) begin
      r_next_o = rem_tbl[v];
`ifdef QUOTIENT_EN
      q_dig_o  = dig_tbl[v];
`endif
    end
  end

endmodule

// File: rtl/div_const_seq_ctrl.sv
// Sequenced constant-divider controller. It computes x mod D, and with QUOTIENT_EN
// also x div D. One step unit is reused for every CHUNK-bit digit, MSB first.
// Macro QUOTIENT_EN: when defined, the quotient register and the q port exist.
//
// Handshake: an input transfer happens on a rising edge when in_valid && in_ready.
// An output transfer happens when out_valid && out_ready. in_ready is high in IDLE,
// or in DONE while the consumer takes the result, which allows back-to-back operation.
// While the controller is busy, in_valid is ignored and the producer must hold x.
// r and q are held stable while out_valid && !out_ready.
module div_const_seq_ctrl
  import div_const_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  output logic         out_valid,
  input  logic         out_ready,
  output res_t         r,
`ifdef QUOTIENT_EN
  output logic [W-1:0] q,
`endif
  output state_t       dbg_state_o
);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    sh_q, sh_d;
  res_t             racc_q, racc_d;
  res_t             r_next;
`ifdef QUOTIENT_EN
  logic [W-1:0]     qacc_q, qacc_d;
  logic [CHUNK-1:0] q_dig;
`endif
  logic             load;

  div_const_step u_step (
    .racc_i   (racc_q),
    .chunk_i  (sh_q[PW-1 -: CHUNK]),
    .r_next_o (r_next)
`ifdef QUOTIENT_EN
    ,
    .q_dig_o  (q_dig)
`endif
  );

  // Handshake outputs decoded from the registered state. in_ready is held low during reset.
  always_comb begin
    in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    out_valid = (state_q == DONE);
  end

  assign load        = in_valid && in_ready;
  assign r           = racc_q;
`ifdef QUOTIENT_EN
  assign q           = qacc_q;
`endif
  assign dbg_state_o = state_q;

  // Next-state and datapath update. A load resets the accumulators and the step counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    racc_d  = racc_q;
`ifdef QUOTIENT_EN
    qacc_d  = qacc_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) state_d = RUN;
      end
      RUN: begin
        racc_d = r_next;
`ifdef QUOTIENT_EN
        // Quotient bits above W come only from the zero padding, so discarding them is safe.
        qacc_d = {qacc_q[W-CHUNK-1:0], q_dig};
`endif
        sh_d   = sh_q << CHUNK;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(NCHUNK - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        if (out_ready) state_d = load ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      sh_d        = '0;
      sh_d[W-1:0] = x;
      racc_d      = '0;
      cnt_d       = '0;
`ifdef QUOTIENT_EN
      qacc_d      = '0;
`endif
    end
  end

  // State and datapath registers with synchronous reset. Reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      racc_q  <= '0;
`ifdef QUOTIENT_EN
      qacc_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      racc_q  <= racc_d;
`ifdef QUOTIENT_EN
      qacc_q  <= qacc_d;
`endif
    end
  end

endmodule
